sync_tx: RTL and testbench

SYNC_TX -- requirements
Module: sync_tx

---
 rtl/sync_tx.sv | 200 ++++++++++++++++++++
 tb/tb_sync_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_tx.sv
// K/J line transmitter: preamble of K/J pairs, LSB-first payload bytes,
// two EOP symbols, then a one-cycle done pulse.
//
// Ports:
//   CLK, RST            clock, async active-high reset
//   start, inject_err   frame request (IDLE only), corrupt last preamble J
//   data_in/valid/last  payload byte stream, data_ready accepts a byte
//   tx_k, tx_j, tx_en   registered line symbols and frame enable
//   busy, done          frame in progress, end-of-frame pulse
module sync_tx #(
  parameter int SYNC_PAIRS = 4,
  parameter int MAX_BYTES  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       inject_err,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_k,
  output logic       tx_j,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP
  } state_t;

  localparam logic [4:0] SYNC_LAST = 5'(2 * SYNC_PAIRS - 1);
  localparam logic [7:0] MAX_B     = 8'(MAX_BYTES);

  state_t     r_state, w_state;
  logic [4:0] r_cnt,   w_cnt;
  logic [2:0] r_bit,   w_bit;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_bytes, w_bytes;
  logic       r_last,  w_last;
  logic       r_err,   w_err;
  logic       r_eop,   w_eop;
  logic       r_k, r_j, r_en, r_busy, r_done;
  logic       w_k, w_j, w_en, w_busy, w_done;
  logic       w_ready;
  logic       w_load;
  logic       w_to_eop;
  logic [4:0] w_cnt_inc;
  logic [2:0] w_bit_inc;

  assign w_cnt_inc = r_cnt + 5'd1;
  assign w_bit_inc = r_bit + 3'd1;

  // Ready opens a one-cycle window at the last preamble symbol and at
  // bit 7 of each non-final byte, so the next byte follows seamlessly.
  always_comb begin
    w_ready = 1'b0;
    unique case (r_state)
      S_SYNC:  w_ready = (r_cnt == SYNC_LAST);
      S_DATA:  w_ready = (r_bit == 3'd7) && !r_last
                         && (r_bytes < MAX_B);
      default: w_ready = 1'b0;
    endcase
  end

  assign data_ready = w_ready;

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_bytes  = r_bytes;
    w_last   = r_last;
    w_err    = r_err;
    w_eop    = r_eop;
    w_k      = 1'b0;
    w_j      = 1'b0;
    w_en     = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_load   = 1'b0;
    w_to_eop = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_SYNC;
          w_cnt   = 5'd0;
          w_err   = inject_err;
          w_bytes = 8'd0;
          w_last  = 1'b0;
          w_k     = 1'b1;
          w_en    = 1'b1;
          w_busy  = 1'b1;
        end
      end
      S_SYNC: begin
        w_en   = 1'b1;
        w_busy = 1'b1;
        if (r_cnt != SYNC_LAST) begin
          w_cnt = w_cnt_inc;
          // even index is K; a latched error turns the final J into K
          w_k = !w_cnt_inc[0]
                || (r_err && (w_cnt_inc == SYNC_LAST));
          w_j = !w_k;
        end else if (data_valid) begin
          w_load = 1'b1;
        end else begin
          w_to_eop = 1'b1;
        end
      end
      S_DATA: begin
        w_en   = 1'b1;
        w_busy = 1'b1;
        if (r_bit != 3'd7) begin
          w_bit = w_bit_inc;
          w_k   = r_shift[w_bit_inc];
          w_j   = !r_shift[w_bit_inc];
        end else if (w_ready && data_valid) begin
          w_load = 1'b1;
        end else begin
          w_to_eop = 1'b1;
        end
      end
      S_EOP: begin
        if (!r_eop) begin
          w_eop  = 1'b1;
          w_k    = 1'b1;
          w_j    = 1'b1;
          w_en   = 1'b1;
          w_busy = 1'b1;
        end else begin
          w_eop   = 1'b0;
          w_state = S_IDLE;
          w_done  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (w_load) begin
      w_state = S_DATA;
      w_shift = data_in;
      w_last  = data_last;
      w_bytes = r_bytes + 8'd1;
      w_bit   = 3'd0;
      w_k     = data_in[0];
      w_j     = !data_in[0];
    end
    if (w_to_eop) begin
      w_state = S_EOP;
      w_eop   = 1'b0;
      w_k     = 1'b1;
      w_j     = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_bytes <= 8'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_eop   <= 1'b0;
      r_k     <= 1'b0;
      r_j     <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_bytes <= w_bytes;
      r_last  <= w_last;
      r_err   <= w_err;
      r_eop   <= w_eop;
      r_k     <= w_k;
      r_j     <= w_j;
      r_en    <= w_en;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign tx_k  = r_k;
  assign tx_j  = r_j;
  assign tx_en = r_en;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_sync_tx.sv
// Testbench for sync_tx: random frames against a symbol-list model,
// checked by an independent monitor through a scoreboard queue.
module tb_sync_tx;

  localparam int P    = 4;
  localparam int MAXB = 16;
  localparam int LIM  = 2 * P + 8 * MAXB + 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       inject_err = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_ready;
  logic       tx_k, tx_j, tx_en, busy, done;

  sync_tx #(.SYNC_PAIRS(P), .MAX_BYTES(MAXB)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .inject_err(inject_err), .data_in(data_in),
    .data_valid(data_valid), .data_last(data_last),
    .data_ready(data_ready), .tx_k(tx_k), .tx_j(tx_j),
    .tx_en(tx_en), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_sym[$];
  int exp_len[$];
  int mon_cnt = 0;
  logic [7:0] fb[32];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : mon
    logic [1:0] s;
    if (!RST) begin
      if (tx_en) begin
        mon_cnt++;
        if (exp_sym.size() == 0) begin
          chk("sym_unexpected", 1, 0);
        end else begin
          s = exp_sym.pop_front();
          chk("symbol", int'({tx_k, tx_j}), int'(s));
        end
        chk("busy_in_frame", int'(busy), 1);
      end
      if (done) begin
        chk("busy_at_done", int'(busy), 0);
        if (exp_len.size() == 0)
          chk("done_unexpected", 1, 0);
        else
          chk("frame_len", mon_cnt, exp_len.pop_front());
        mon_cnt = 0;
      end
    end
  end

  task automatic drive(input int idx, input int n, input bit ul);
    data_valid = (idx < n);
    data_in    = (idx < n) ? fb[idx] : 8'($urandom);
    data_last  = ul && (idx == n - 1);
  endtask

  task automatic run_frame(input int n, input bit ul, input bit err,
                           input bit b2b, input int abort_at,
                           input int b0);
    int  nacc, idx, cyc, rdy;
    bit  acc, fin;
    nacc = (n > MAXB) ? MAXB : n;
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    if (b0 >= 0) fb[0] = 8'(b0);
    for (int p = 0; p < P; p++) begin
      exp_sym.push_back(2'b10);
      exp_sym.push_back((err && p == P - 1) ? 2'b10 : 2'b01);
    end
    for (int i = 0; i < nacc; i++)
      for (int b = 0; b < 8; b++)
        exp_sym.push_back({fb[i][b], ~fb[i][b]});
    exp_sym.push_back(2'b11);
    exp_sym.push_back(2'b11);
    exp_len.push_back(2 * P + 8 * nacc + 2);
    if (!b2b)
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK);
        #1;
      end
    start = 1'b1;
    inject_err = err;
    idx = 0;
    cyc = 0;
    rdy = 0;
    fin = 0;
    drive(idx, n, ul);
    while (!fin) begin
      @(negedge CLK);
      acc = data_ready && data_valid;
      if (data_ready) rdy++;
      @(posedge CLK);
      #1;
      cyc++;
      start = 1'b0;
      inject_err = 1'($urandom);
      if (acc) idx++;
      drive(idx, n, ul);
      if (abort_at != 0 && cyc == abort_at) begin
        RST = 1'b1;
        #1;
        chk("rst_outputs", int'({tx_k, tx_j, tx_en, busy, done,
                                 data_ready}), 0);
        exp_sym.delete();
        exp_len.delete();
        mon_cnt = 0;
        data_valid = 1'b0;
        data_last = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("idle_after_rst", int'({tx_en, busy}), 0);
        @(posedge CLK);
        #1;
        fin = 1;
      end else if (done) begin
        fin = 1;
      end else if (cyc > LIM) begin
        chk("frame_timeout", cyc, LIM);
        fin = 1;
      end else if (busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
      end
    end
    data_valid = 1'b0;
    data_last = 1'b0;
    if (abort_at == 0)
      chk("ready_count", rdy,
          (nacc == MAXB || (ul && n > 0)) ? nacc : nacc + 1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_state", int'({tx_k, tx_j, tx_en, busy, done,
                             data_ready}), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    run_frame(1, 1, 0, 0, 0, 'hA5);
    run_frame(0, 0, 0, 0, 0, -1);
    run_frame(1, 1, 1, 0, 0, 'hA5);
    run_frame(20, 0, 0, 0, 0, -1);
    run_frame(3, 1, 0, 1, 0, -1);
    run_frame(2, 0, 0, 1, 0, -1);
    run_frame(0, 1, 1, 1, 0, -1);
    run_frame(18, 1, 0, 0, 0, -1);
    run_frame(3, 1, 0, 0, 12, -1);
    run_frame(1, 1, 0, 0, 0, 'hA5);
    for (int k = 0; k < 20; k++)
      run_frame($urandom_range(0, 20), 1'($urandom),
                1'($urandom), 1'($urandom), 0, -1);
    repeat (4) @(negedge CLK);
    chk("queue_drained", exp_sym.size() + exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
